// File: rtl/i2s_tdm_tx.sv
// i2s_tdm_tx: PCM serialiser for 2-channel I2S / left-justified or N-channel TDM.
// Samples come in on an Avalon-ST sink and wait in a small FIFO. A frame is only
// sent from the FIFO when a full set of channels is queued, so channel alignment
// always holds. BCLK/LRCLK are divided down from clk_clk.
// Optional build macro: I2S_TDM_TX_MUTE_EN adds a 'mute' input, sampled at frame start.
module i2s_tdm_tx #(
  parameter int DATA_W     = 24,
  parameter int SLOT_W     = 32,
  parameter int CHANNELS   = 2,
  parameter int BCLK_DIV   = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int MODE       = 0
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset,
  input  logic [DATA_W-1:0]             asi_data,
  input  logic                          asi_valid,
  output logic                          asi_ready,
  input  logic                          enable,
`ifdef I2S_TDM_TX_MUTE_EN
  input  logic                          mute,
`endif
  output logic                          tx_bclk,
  output logic                          tx_lrclk,
  output logic                          tx_sdata,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          underrun,
  input  logic                          underrun_clr
);

  localparam int DIV_W  = $clog2(BCLK_DIV);
  localparam int BIT_W  = $clog2(SLOT_W);
  localparam int SLC_W  = $clog2(CHANNELS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FILL_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t              state, state_nxt;
  logic                active;
  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [SLC_W-1:0]    slot_cnt;
  logic                bclk_fall, slot_start, frame_start, frame_end;

  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic                push, pop, have_frame;
  logic                pop_q, send_q, pop_now, send_now, mute_now;

  logic [SLOT_W-1:0]   load_word, sh_q;
  logic                raw_bit, prev_bit;

  // Counter decode: a frame is CHANNELS slots of SLOT_W bit clocks
  assign bclk_fall   = active && (div_cnt == '0);
  assign slot_start  = bclk_fall && (bit_cnt == '0);
  assign frame_start = slot_start && (slot_cnt == '0);
  assign frame_end   = active && (div_cnt == DIV_W'(BCLK_DIV-1)) &&
                       (bit_cnt == BIT_W'(SLOT_W-1)) && (slot_cnt == SLC_W'(CHANNELS-1));

  // FIFO handshake; sink is held off while reset is asserted
  assign asi_ready  = !reset_reset && (fill < FILL_W'(FIFO_DEPTH));
  assign push       = asi_valid && asi_ready;
  assign have_frame = (fill >= FILL_W'(CHANNELS));

`ifdef I2S_TDM_TX_MUTE_EN
  assign mute_now = mute;
`else
  assign mute_now = 1'b0;
`endif

  // The pop/send decision is made once per frame and held for the remaining slots
  assign pop_now  = frame_start ? have_frame : pop_q;
  assign send_now = frame_start ? (have_frame && !mute_now) : send_q;
  assign pop      = slot_start && pop_now;

  // FSM state register
  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= IDLE;
    else             state <= state_nxt;
  end

  // FSM next state: stopping always waits for the frame boundary
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (enable) state_nxt = RUN;
      RUN:  if (!enable) state_nxt = frame_end ? IDLE : STOP;
      STOP: if (enable) state_nxt = RUN;
            else if (frame_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    active = (state == RUN) || (state == STOP);
  end

  // BCLK divider, bit and slot counters; parked at zero while idle
  always_ff @(posedge clk_clk) begin
    if (reset_reset || !active) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      slot_cnt <= '0;
    end else if (div_cnt == DIV_W'(BCLK_DIV-1)) begin
      div_cnt <= '0;
      if (bit_cnt == BIT_W'(SLOT_W-1)) begin
        bit_cnt  <= '0;
        slot_cnt <= (slot_cnt == SLC_W'(CHANNELS-1)) ? '0 : slot_cnt + 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // FIFO storage (no reset needed on the data array)
  always_ff @(posedge clk_clk) begin
    if (push) mem[wr_ptr] <= asi_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  // Frame-level pop/send flags latched at frame start
  always_ff @(posedge clk_clk) begin
    if (reset_reset || !active) begin
      pop_q  <= 1'b0;
      send_q <= 1'b0;
    end else if (frame_start) begin
      pop_q  <= have_frame;
      send_q <= have_frame && !mute_now;
    end
  end

  // Slot word: sample left-aligned, LSBs zero-padded; all zeros for a silent frame
  always_comb begin
    load_word = '0;
    if (send_now) load_word[SLOT_W-1 -: DATA_W] = mem[rd_ptr];
  end

  assign raw_bit = slot_start ? load_word[SLOT_W-1] : sh_q[SLOT_W-1];

  // MSB-first shifter, advanced once per bit clock
  always_ff @(posedge clk_clk) begin
    if (reset_reset || !active) sh_q <= '0;
    else if (bclk_fall)         sh_q <= slot_start ? (load_word << 1) : (sh_q << 1);
  end

  // Sticky underrun; a new underrun beats a same-cycle clear
  always_ff @(posedge clk_clk) begin
    if (reset_reset)                     underrun <= 1'b0;
    else if (frame_start && !have_frame) underrun <= 1'b1;
    else if (underrun_clr)               underrun <= 1'b0;
  end

  // Registered serial outputs; I2S mode sends each bit one BCLK late via prev_bit
  always_ff @(posedge clk_clk) begin
    if (reset_reset || !active) begin
      tx_bclk  <= 1'b0;
      tx_lrclk <= 1'b0;
      tx_sdata <= 1'b0;
      prev_bit <= 1'b0;
    end else begin
      tx_bclk  <= (div_cnt >= DIV_W'(BCLK_DIV/2));
      tx_lrclk <= (CHANNELS == 2) ? slot_cnt[0] : ((slot_cnt == '0) && (bit_cnt == '0));
      if (bclk_fall) begin
        tx_sdata <= (MODE == 1) ? raw_bit : prev_bit;
        prev_bit <= raw_bit;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// tb_i2s_tdm_tx: two instances share stimulus (2-ch I2S and 4-ch TDM left-justified);
// outputs are compared with a frame-level bitstream model built from the sample queue.
module tb_i2s_tdm_tx;
  localparam int DW  = 24;
  localparam int SW  = 32;
  localparam int DIV = 4;

  logic          clk = 0, rst = 0, valid = 0, en = 0, clr = 0;
  logic [DW-1:0] data = '0;
  logic          a_ready, a_bclk, a_lr, a_sd, a_ur;
  logic          b_ready, b_bclk, b_lr, b_sd, b_ur;
  logic [3:0]    a_fill, b_fill;

  int            n_chk = 0, n_pass = 0;
  logic [DW-1:0] mq[$];
  bit            um;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          exp_ready;
    int            exp_fill;
  } vec_t;
  vec_t tbl[10];

  always #5 clk = ~clk;

  i2s_tdm_tx #(.DATA_W(DW), .SLOT_W(SW), .CHANNELS(2), .BCLK_DIV(DIV), .FIFO_DEPTH(8), .MODE(0)) u_a (
    .clk_clk(clk), .reset_reset(rst), .asi_data(data), .asi_valid(valid), .asi_ready(a_ready),
    .enable(en), .tx_bclk(a_bclk), .tx_lrclk(a_lr), .tx_sdata(a_sd), .fill(a_fill),
    .underrun(a_ur), .underrun_clr(clr));

  i2s_tdm_tx #(.DATA_W(DW), .SLOT_W(SW), .CHANNELS(4), .BCLK_DIV(DIV), .FIFO_DEPTH(8), .MODE(1)) u_b (
    .clk_clk(clk), .reset_reset(rst), .asi_data(data), .asi_valid(valid), .asi_ready(b_ready),
    .enable(en), .tx_bclk(b_bclk), .tx_lrclk(b_lr), .tx_sdata(b_sd), .fill(b_fill),
    .underrun(b_ur), .underrun_clr(clr));

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Reset for one cycle; checks sink held off during reset and idle values after
  task automatic do_reset();
    @(negedge clk); rst = 1; en = 0; valid = 0; clr = 0;
    @(negedge clk);
    chk("ready during reset", a_ready, 0);
    rst = 0;
    @(negedge clk);
    chk("ready after reset", a_ready, 1);
    chk("fill after reset", a_fill, 0);
    chk("tx idle after reset", {a_bclk, a_lr, a_sd}, 0);
    chk("underrun after reset", a_ur, 0);
    mq.delete();
    um = 0;
  endtask

  task automatic push(input logic [DW-1:0] d);
    @(negedge clk); valid = 1; data = d;
    if (a_ready) mq.push_back(d);
    @(negedge clk); valid = 0;
  endtask

  // Enable and capture nfr frames plus an idle tail; enable is dropped 40 clk into
  // the last frame, with an optional pause/resume window inside the run.
  task automatic run(input int sel, input int nfr, input int pause_at, input int resume_at,
                     input bit clr_start, input string nm);
    int ch, frc, total, drop_c, fexp, k, mb, ml, ms, mf;
    bit raw [0:1023];
    bit pe  [0:1279];
    logic [DW-1:0] w;
    bit p, eb, el, es;
    logic sb, sl, ss;
    logic [3:0] sf;
    ch = (sel != 0) ? 4 : 2;
    frc = ch * SW * DIV;
    total = nfr * frc + 8;
    drop_c = (nfr - 1) * frc + 40;
    fexp = mq.size();
    mb = 0; ml = 0; ms = 0; mf = 0;
    for (int c = 0; c < 1280; c++) pe[c] = 0;
    for (int f = 0; f < nfr; f++) begin
      p = (mq.size() >= ch);
      if (!p) um = 1;
      for (int s = 0; s < ch; s++) begin
        w = '0;
        if (p) begin
          w = mq.pop_front();
          pe[f * frc + s * SW * DIV] = 1;
        end
        for (int b = 0; b < SW; b++) raw[(f * ch + s) * SW + b] = (b < DW) ? w[DW-1-b] : 1'b0;
      end
    end
    @(negedge clk); en = 1; clr = clr_start;
    @(negedge clk);
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      if (c == 0 && clr_start) begin
        chk({nm, " underrun beats clr"}, (sel != 0) ? b_ur : a_ur, 1);
        clr = 0;
      end
      if (c == pause_at)  en = 0;
      if (c == resume_at) en = 1;
      if (c == drop_c)    en = 0;
      if (pe[c]) fexp--;
      if (c < nfr * frc) begin
        k  = c / DIV;
        eb = (c % DIV) >= DIV / 2;
        el = (sel != 0) ? (k % (ch * SW) == 0) : ((k / SW) % 2 == 1);
        es = (sel != 0) ? raw[k] : ((k == 0) ? 1'b0 : raw[k-1]);
      end else begin
        eb = 0; el = 0; es = 0;
      end
      sb = (sel != 0) ? b_bclk : a_bclk;
      sl = (sel != 0) ? b_lr   : a_lr;
      ss = (sel != 0) ? b_sd   : a_sd;
      sf = (sel != 0) ? b_fill : a_fill;
      if (sb !== eb) mb++;
      if (sl !== el) ml++;
      if (ss !== es) ms++;
      if (sf !== 4'(fexp)) mf++;
    end
    chk({nm, " bclk mismatching clocks"}, mb, 0);
    chk({nm, " lrclk mismatching clocks"}, ml, 0);
    chk({nm, " sdata mismatching clocks"}, ms, 0);
    chk({nm, " fill mismatching clocks"}, mf, 0);
    chk({nm, " underrun at end"}, (sel != 0) ? b_ur : a_ur, um);
  endtask

  initial begin
    for (int i = 0; i < 10; i++) begin
      tbl[i].v         = (i < 9);
      tbl[i].d         = DW'(i + 1);
      tbl[i].exp_ready = (i < 8);
      tbl[i].exp_fill  = (i < 8) ? i + 1 : 8;
    end

    // Basic stereo frame
    do_reset();
    push(24'hABCDEF);
    push(24'h123456);
    run(0, 1, -1, -1, 0, "basic");
    chk("basic fill drained", a_fill, 0);

    // FIFO fill with valid held: 9th sample refused
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      valid = tbl[i].v;
      data  = tbl[i].d;
      chk($sformatf("table ready[%0d]", i), a_ready, tbl[i].exp_ready);
      if (valid && a_ready) mq.push_back(data);
      @(negedge clk);
      chk($sformatf("table fill[%0d]", i), a_fill, tbl[i].exp_fill);
    end
    valid = 0;

    // Two frames with enable dropped and re-raised inside the first frame
    run(0, 2, 40, 100, 0, "seamless");

    // Random sample counts and data, underrun or not by queue depth
    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(0, 4);
      if (mq.size() + n > 8) n = 8 - mq.size();
      for (int j = 0; j < n; j++) push(DW'($urandom));
      run(0, 2, -1, -1, 0, $sformatf("rand%0d", r));
    end

    // Underrun: one sample queued, clear held into frame start
    do_reset();
    push(24'h5A5A5A);
    run(0, 1, -1, -1, 1, "underrun");
    chk("underrun fill kept", a_fill, 1);
    @(negedge clk); clr = 1;
    @(negedge clk); clr = 0;
    chk("underrun cleared", a_ur, 0);
    um = 0;
    run(0, 1, -1, -1, 0, "underrun2");

    // Reset in the middle of a frame
    for (int j = 0; j < 6; j++) push(DW'($urandom));
    @(negedge clk); en = 1;
    @(negedge clk);
    repeat (151) @(negedge clk);
    chk("midframe fill", a_fill, 5);
    chk("midframe underrun held", a_ur, 1);
    rst = 1;
    @(negedge clk);
    chk("midframe reset tx", {a_bclk, a_lr, a_sd}, 0);
    chk("midframe reset fill", a_fill, 0);
    chk("midframe reset underrun", a_ur, 0);
    chk("midframe reset ready", a_ready, 0);
    rst = 0; en = 0;
    @(negedge clk);
    chk("midframe ready after", a_ready, 1);

    // TDM, 4 channels, left-justified
    do_reset();
    push(24'h800000);
    push(24'h400000);
    push(24'h200000);
    push(24'h100000);
    run(1, 1, -1, -1, 0, "tdm");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
